// File: rtl/iq_freeze_fsm.sv
// iq_freeze_fsm
//   Controls when the IQ compensator may adapt its weights. The controller
//   waits for a run of signal-present cycles, lets the compensator adapt, and
//   freezes the weights once they have settled or the adapt window has run
//   out. Losing the signal while adapting returns to detection.
//
// Ports
//   clk            clock
//   RESETn         synchronous, active-low reset
//   enable         block enable (level); low forces IDLE and clears flags
//   restart        single-cycle request to re-acquire
//   Iy, Qy         signed 4-bit compensated IQ samples
//   Wr, Wj         signed 13-bit compensator weights
//   freeze_iqcomp  1 = compensator holds its weights (0 only in ADAPT)
//   fsm_state      IDLE=00, DETECT=01, ADAPT=10, FROZEN=11
//   settled        sticky, set on a settle-based freeze
//   timeout        sticky, set on a timeout-based freeze
//   start_det      one-cycle pulse in the first ADAPT cycle
module iq_freeze_fsm #(
  parameter int ENERGY_TH  = 8,
  parameter int ACT_CNT    = 16,
  parameter int SETTLE_TOL = 4,
  parameter int SETTLE_CNT = 64,
  parameter int TIMEOUT    = 4095,
  parameter int LOSS_CNT   = 32
) (
  input  logic               clk,
  input  logic               RESETn,
  input  logic               enable,
  input  logic               restart,
  input  logic signed [3:0]  Iy,
  input  logic signed [3:0]  Qy,
  input  logic signed [12:0] Wr,
  input  logic signed [12:0] Wj,
  output logic               freeze_iqcomp,
  output logic [1:0]         fsm_state,
  output logic               settled,
  output logic               timeout,
  output logic               start_det
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DETECT = 2'b01,
    ADAPT  = 2'b10,
    FROZEN = 2'b11
  } state_t;

  localparam int ACT_W  = (ACT_CNT    > 1) ? $clog2(ACT_CNT)    : 1;
  localparam int SET_W  = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
  localparam int LOSS_W = (LOSS_CNT   > 1) ? $clog2(LOSS_CNT)   : 1;

  localparam logic [ACT_W-1:0]  ACT_TERM  = ACT_W'(ACT_CNT - 1);
  localparam logic [SET_W-1:0]  SET_TERM  = SET_W'(SETTLE_CNT - 1);
  localparam logic [LOSS_W-1:0] LOSS_TERM = LOSS_W'(LOSS_CNT - 1);
  localparam logic [15:0]       TO_TERM   = 16'(TIMEOUT - 1);
  localparam logic [7:0]        ETH       = 8'(ENERGY_TH);
  localparam logic [13:0]       TOL       = 14'(SETTLE_TOL);

  state_t             state_q;
  logic [ACT_W-1:0]   act_q,  act_d;
  logic [SET_W-1:0]   set_q,  set_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic [15:0]        to_q,   to_d;
  logic [12:0]        wr_prev_q, wj_prev_q;
  logic               settled_q, timeout_q, start_det_q;

  // Signal energy: each square is at most 64, so the sum fits 8 bits unsigned.
  logic signed [7:0] iy_ext, qy_ext, iy_sq, qy_sq;
  logic [7:0]        energy;
  logic              present;

  assign iy_ext  = {{4{Iy[3]}}, Iy};
  assign qy_ext  = {{4{Qy[3]}}, Qy};
  assign iy_sq   = iy_ext * iy_ext;
  assign qy_sq   = qy_ext * qy_ext;
  assign energy  = iy_sq + qy_sq;
  assign present = (energy >= ETH);

  // Weight deltas in 14 bits so a full-range swing cannot overflow.
  logic [13:0] dwr, dwj, adwr, adwj;
  logic        stable;

  assign dwr    = {Wr[12], Wr} - {wr_prev_q[12], wr_prev_q};
  assign dwj    = {Wj[12], Wj} - {wj_prev_q[12], wj_prev_q};
  assign adwr   = dwr[13] ? (~dwr + 14'd1) : dwr;
  assign adwj   = dwj[13] ? (~dwj + 14'd1) : dwj;
  assign stable = (adwr <= TOL) && (adwj <= TOL);

  // Saturating increments; the FSM decides when to use or clear them.
  assign act_d  = (act_q  == ACT_TERM)  ? act_q  : act_q  + ACT_W'(1);
  assign set_d  = (set_q  == SET_TERM)  ? set_q  : set_q  + SET_W'(1);
  assign loss_d = (loss_q == LOSS_TERM) ? loss_q : loss_q + LOSS_W'(1);
  assign to_d   = (to_q   == TO_TERM)   ? to_q   : to_q   + 16'd1;

  always_ff @(posedge clk) begin
    start_det_q <= 1'b0;
    if (!RESETn) begin
      state_q   <= IDLE;
      act_q     <= '0;
      set_q     <= '0;
      loss_q    <= '0;
      to_q      <= '0;
      wr_prev_q <= '0;
      wj_prev_q <= '0;
      settled_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wr_prev_q <= Wr;
      wj_prev_q <= Wj;
      if (!enable) begin
        state_q   <= IDLE;
        act_q     <= '0;
        set_q     <= '0;
        loss_q    <= '0;
        to_q      <= '0;
        settled_q <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            act_q   <= '0;
            set_q   <= '0;
            loss_q  <= '0;
            to_q    <= '0;
            state_q <= DETECT;
          end
          DETECT: begin
            if (restart) begin
              act_q <= '0;
            end else if (present) begin
              if (act_q == ACT_TERM) begin
                state_q     <= ADAPT;
                start_det_q <= 1'b1;
                act_q       <= '0;
                set_q       <= '0;
                loss_q      <= '0;
                to_q        <= '0;
              end else begin
                act_q <= act_d;
              end
            end else begin
              act_q <= '0;
            end
          end
          ADAPT: begin
            // Exit priority: restart, then settle, timeout, loss.
            if (restart || (stable && set_q == SET_TERM) || (to_q == TO_TERM)
                || (!present && loss_q == LOSS_TERM)) begin
              act_q  <= '0;
              set_q  <= '0;
              loss_q <= '0;
              to_q   <= '0;
              if (restart) begin
                state_q <= DETECT;
              end else if (stable && set_q == SET_TERM) begin
                state_q   <= FROZEN;
                settled_q <= 1'b1;
              end else if (to_q == TO_TERM) begin
                state_q   <= FROZEN;
                timeout_q <= 1'b1;
              end else begin
                state_q <= DETECT;
              end
            end else begin
              set_q  <= stable  ? set_d  : '0;
              loss_q <= present ? '0     : loss_d;
              to_q   <= to_d;
            end
          end
          FROZEN: begin
            if (restart) begin
              state_q   <= DETECT;
              settled_q <= 1'b0;
              timeout_q <= 1'b0;
              act_q     <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign freeze_iqcomp = (state_q != ADAPT);
  assign fsm_state     = state_q;
  assign settled       = settled_q;
  assign timeout       = timeout_q;
  assign start_det     = start_det_q;

endmodule

// File: tb/tb_iq_freeze_fsm.sv
// Directed bench for iq_freeze_fsm. Stimulus pushes the expected output
// vector for the cycle just clocked; a monitor on the falling edge pops and
// compares every entry tagged with the current cycle.
module tb_iq_freeze_fsm;

  localparam logic [1:0] S_IDLE = 2'b00, S_DET = 2'b01, S_ADP = 2'b10, S_FRZ = 2'b11;

  logic               clk = 1'b0;
  logic               RESETn, enable, restart;
  logic signed [3:0]  Iy, Qy;
  logic signed [12:0] Wr, Wj;
  logic               freeze_iqcomp, settled, timeout, start_det;
  logic [1:0]         fsm_state;

  iq_freeze_fsm #(
    .ENERGY_TH(8), .ACT_CNT(16), .SETTLE_TOL(4),
    .SETTLE_CNT(64), .TIMEOUT(4095), .LOSS_CNT(32)
  ) dut (
    .clk(clk), .RESETn(RESETn), .enable(enable), .restart(restart),
    .Iy(Iy), .Qy(Qy), .Wr(Wr), .Wj(Wj),
    .freeze_iqcomp(freeze_iqcomp), .fsm_state(fsm_state),
    .settled(settled), .timeout(timeout), .start_det(start_det)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [1:0]  st;
    logic        frz, set, to, sd;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never compared (now %0d)",
                 mon_e.name, mon_e.cyc, cyc);
      end else if ({fsm_state, freeze_iqcomp, settled, timeout, start_det} !==
                   {mon_e.st, mon_e.frz, mon_e.set, mon_e.to, mon_e.sd}) begin
        errors++;
        $display("FAIL %s @%0d: got st=%b frz=%b set=%b to=%b sd=%b, want st=%b frz=%b set=%b to=%b sd=%b",
                 mon_e.name, cyc, fsm_state, freeze_iqcomp, settled, timeout, start_det,
                 mon_e.st, mon_e.frz, mon_e.set, mon_e.to, mon_e.sd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] st, input logic fz,
                            input logic se, input logic to, input logic sd);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.st = st; e.frz = fz; e.set = se; e.to = to; e.sd = sd;
    sbq.push_back(e);
  endtask

  // 15 present cycles stay in DETECT, the 16th enters ADAPT with start_det.
  task automatic acquire(input string nm, input logic step_w);
    for (int i = 1; i <= 15; i++) begin
      if (step_w) Wr = Wr + 13'sd5;
      step();
      expect_out({nm, "_det"}, S_DET, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    if (step_w) Wr = Wr + 13'sd5;
    step();
    expect_out({nm, "_enter"}, S_ADP, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Wr steps by 5 while k < hold_from, then holds; 4095 ADAPT cycles.
  task automatic run_adapt(input string nm, input int unsigned hold_from,
                           input logic exp_set, input logic exp_to);
    for (int unsigned k = 1; k <= 4095; k++) begin
      if (k < hold_from) Wr = Wr + 13'sd5;
      step();
      if (k == 1)    expect_out({nm, "_first"}, S_ADP, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 4094) expect_out({nm, "_pre"},   S_ADP, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    expect_out({nm, "_frozen"}, S_FRZ, 1'b1, exp_set, exp_to, 1'b0);
  endtask

  initial begin
    RESETn = 1'b0; enable = 1'b0; restart = 1'b0;
    Iy = '0; Qy = '0; Wr = '0; Wj = '0;
    step(); step();
    expect_out("reset", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);

    // Acquisition with energy 13.
    RESETn = 1'b1; enable = 1'b1; Iy = 4'sd3; Qy = 4'sd2;
    step();
    expect_out("idle_to_det", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);
    acquire("acq1", 1'b0);
    step();
    expect_out("sd_one_cycle", S_ADP, 1'b0, 1'b0, 1'b0, 1'b0);

    // Loss: energy 2 for 32 cycles drops back to DETECT.
    Iy = 4'sd1; Qy = 4'sd1;
    for (int i = 1; i <= 31; i++) begin
      step();
      if (i == 31) expect_out("loss_pre", S_ADP, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    expect_out("loss_exit", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);

    // Gap on the 15th present cycle restarts the count.
    Wr = 13'sd100; Wj = -13'sd50; Iy = 4'sd3; Qy = 4'sd2;
    for (int i = 1; i <= 14; i++) step();
    Iy = 4'sd0; Qy = 4'sd0;
    step();
    expect_out("gap_det", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);
    Iy = 4'sd3; Qy = 4'sd2;
    acquire("acq2", 1'b0);

    // Constant weights: freeze after 64 settled cycles.
    for (int i = 1; i <= 63; i++) begin
      step();
      if (i == 1 || i == 63) expect_out("settle_adapt", S_ADP, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    expect_out("settle_frz", S_FRZ, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) step();
    expect_out("frz_hold", S_FRZ, 1'b1, 1'b1, 1'b0, 1'b0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_out("frz_restart", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout with weights never settling.
    acquire("acq3", 1'b1);
    run_adapt("tmo", 5000, 1'b0, 1'b1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_out("tmo_restart", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);

    // Settle and timeout terminal on the same cycle: settle wins.
    acquire("acq4", 1'b1);
    run_adapt("both", 4032, 1'b1, 1'b0);

    // enable=0 overrides restart in FROZEN.
    enable = 1'b0; restart = 1'b1;
    step();
    expect_out("disable_frz", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    restart = 1'b0; enable = 1'b1;
    step();
    expect_out("reenable", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart in ADAPT, then reset while start_det is high.
    acquire("acq5", 1'b0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    expect_out("adapt_restart", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);
    acquire("acq6", 1'b0);
    RESETn = 1'b0;
    step();
    expect_out("reset_adapt1", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("reset_adapt2", S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    RESETn = 1'b1;
    step();
    expect_out("post_reset", S_DET, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
